univ_counter_cmd_ctrl: RTL and testbench

//  Command sequencer for a universal binary counter (clear/load/enable/up ports, max/min ticks).

---
 rtl/univ_counter_cmd_ctrl_if.sv | 25 ++
 rtl/univ_counter_cmd_ctrl.sv | 142 ++++++++++++++
 tb/tb_univ_counter_cmd_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/univ_counter_cmd_ctrl_if.sv
// Host-side command/completion bundle for the universal counter command sequencer.
interface univ_counter_cmd_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_arg;
    logic         abort;
    logic         done_tick;
    logic [1:0]   done_status;
    logic [N-1:0] steps;
    logic         busy;
    logic [N-1:0] count;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, abort,
        input  cmd_ready, done_tick, done_status, steps, busy, count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, abort,
        output cmd_ready, done_tick, done_status, steps, busy, count
    );
endinterface

// File: rtl/univ_counter_cmd_ctrl.sv
// Command sequencer for a universal binary counter: takes one host command at a time
// and drives clear/load/enable/up until it completes, then reports status and step count.
module univ_counter_cmd_ctrl #(
    parameter int unsigned N   = 8,
    parameter bit          SAT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    univ_counter_cmd_ctrl_if.slave host,
    output logic                   ctr_syn_clr,
    output logic                   ctr_load,
    output logic                   ctr_en,
    output logic                   ctr_up,
    output logic [N-1:0]           ctr_d,
    input  logic [N-1:0]           ctr_q,
    input  logic                   ctr_max_tick,
    input  logic                   ctr_min_tick
);
    localparam logic [2:0] OP_CLEAR     = 3'd0;
    localparam logic [2:0] OP_LOAD      = 3'd1;
    localparam logic [2:0] OP_STEP_UP   = 3'd2;
    localparam logic [2:0] OP_STEP_DOWN = 3'd3;
    localparam logic [2:0] OP_RUN_MAX   = 3'd4;
    localparam logic [2:0] OP_RUN_MIN   = 3'd5;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_SATURATED = 2'b01;
    localparam logic [1:0] ST_ABORTED   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL   = 2'b11;

    typedef enum logic [2:0] {IDLE, CLR, LD, STEP, RUN, DONE} state_t;

    state_t       state;
    logic [N-1:0] arg_q;
    logic [N-1:0] remaining;
    logic [N-1:0] step_cnt;
    logic [N-1:0] steps_q;
    logic [1:0]   status_q;
    logic         dir;

    logic         live_c;
    logic         tick_c;
    logic         en_c;

    // Abort suppresses every counter strobe in the cycle it is seen.
    assign live_c = !reset && !host.abort;
    assign tick_c = dir ? ctr_max_tick : ctr_min_tick;
    assign en_c   = live_c &&
                    ((state == STEP && remaining != '0 && !(SAT && tick_c)) ||
                     (state == RUN  && !tick_c));

    assign ctr_syn_clr = live_c && (state == CLR);
    assign ctr_load    = live_c && (state == LD);
    assign ctr_en      = en_c;
    assign ctr_up      = en_c && dir;
    assign ctr_d       = ctr_load ? arg_q : '0;

    assign host.cmd_ready   = !reset && (state == IDLE);
    assign host.busy        = !reset && (state != IDLE);
    assign host.done_tick   = !reset && (state == DONE);
    assign host.done_status = status_q;
    assign host.steps       = steps_q;
    assign host.count       = ctr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            arg_q     <= '0;
            remaining <= '0;
            step_cnt  <= '0;
            steps_q   <= '0;
            status_q  <= ST_OK;
            dir       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.cmd_valid) begin
                        arg_q     <= host.cmd_arg;
                        remaining <= host.cmd_arg;
                        step_cnt  <= '0;
                        dir       <= (host.cmd_op == OP_STEP_UP) || (host.cmd_op == OP_RUN_MAX);
                        case (host.cmd_op)
                            OP_CLEAR:                 state <= CLR;
                            OP_LOAD:                  state <= LD;
                            OP_STEP_UP, OP_STEP_DOWN: state <= STEP;
                            OP_RUN_MAX, OP_RUN_MIN:   state <= RUN;
                            default: begin
                                state    <= DONE;
                                status_q <= ST_ILLEGAL;
                                steps_q  <= '0;
                            end
                        endcase
                    end
                end
                CLR, LD: begin
                    state    <= DONE;
                    status_q <= host.abort ? ST_ABORTED : ST_OK;
                    steps_q  <= '0;
                end
                STEP: begin
                    if (host.abort) begin
                        state    <= DONE;
                        status_q <= ST_ABORTED;
                        steps_q  <= step_cnt;
                    end else if (remaining == '0) begin
                        state    <= DONE;
                        status_q <= ST_OK;
                        steps_q  <= step_cnt;
                    end else if (SAT && tick_c) begin
                        state    <= DONE;
                        status_q <= ST_SATURATED;
                        steps_q  <= step_cnt;
                    end else begin
                        remaining <= remaining - N'(1);
                        step_cnt  <= step_cnt + N'(1);
                        // Finish on the last enable so DONE sees the final count.
                        if (remaining == N'(1)) begin
                            state    <= DONE;
                            status_q <= ST_OK;
                            steps_q  <= step_cnt + N'(1);
                        end
                    end
                end
                RUN: begin
                    if (host.abort) begin
                        state    <= DONE;
                        status_q <= ST_ABORTED;
                        steps_q  <= step_cnt;
                    end else if (tick_c) begin
                        state    <= DONE;
                        status_q <= ST_OK;
                        steps_q  <= step_cnt;
                    end else if (step_cnt != '1) begin
                        step_cnt <= step_cnt + N'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_univ_counter_cmd_ctrl.sv
// Directed bench for univ_counter_cmd_ctrl driving a behavioural universal counter.
module tb_univ_counter_cmd_ctrl;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    univ_counter_cmd_ctrl_if #(.N(N)) h ();
    univ_counter_cmd_ctrl_if #(.N(N)) hw ();

    logic         s_clr, s_ld, s_en, s_up, s_max, s_min;
    logic [N-1:0] s_d, s_q;
    logic         w_clr, w_ld, w_en, w_up, w_max, w_min;
    logic [N-1:0] w_d, w_q;

    univ_counter_cmd_ctrl #(.N(N), .SAT(1'b1)) dut (
        .clk(clk), .reset(reset), .host(h),
        .ctr_syn_clr(s_clr), .ctr_load(s_ld), .ctr_en(s_en), .ctr_up(s_up), .ctr_d(s_d),
        .ctr_q(s_q), .ctr_max_tick(s_max), .ctr_min_tick(s_min)
    );

    univ_counter_cmd_ctrl #(.N(N), .SAT(1'b0)) dut_w (
        .clk(clk), .reset(reset), .host(hw),
        .ctr_syn_clr(w_clr), .ctr_load(w_ld), .ctr_en(w_en), .ctr_up(w_up), .ctr_d(w_d),
        .ctr_q(w_q), .ctr_max_tick(w_max), .ctr_min_tick(w_min)
    );

    // Universal binary counters controlled by each sequencer.
    always_ff @(posedge clk) begin
        if (reset || s_clr) s_q <= '0;
        else if (s_ld)      s_q <= s_d;
        else if (s_en)      s_q <= s_up ? s_q + N'(1) : s_q - N'(1);
    end
    always_ff @(posedge clk) begin
        if (reset || w_clr) w_q <= '0;
        else if (w_ld)      w_q <= w_d;
        else if (w_en)      w_q <= w_up ? w_q + N'(1) : w_q - N'(1);
    end
    assign s_max = (s_q == '1);
    assign s_min = (s_q == '0);
    assign w_max = (w_q == '1);
    assign w_min = (w_q == '0);

    logic         sel;
    logic         d_valid, d_abort;
    logic [2:0]   d_op;
    logic [N-1:0] d_arg;

    assign h.cmd_valid  = d_valid & ~sel;
    assign h.abort      = d_abort & ~sel;
    assign h.cmd_op     = d_op;
    assign h.cmd_arg    = d_arg;
    assign hw.cmd_valid = d_valid & sel;
    assign hw.abort     = d_abort & sel;
    assign hw.cmd_op    = d_op;
    assign hw.cmd_arg   = d_arg;

    logic         o_ready, o_done, o_busy, o_clr, o_ld, o_en, o_up;
    logic [1:0]   o_status;
    logic [N-1:0] o_steps, o_q, o_d;
    assign o_ready  = sel ? hw.cmd_ready   : h.cmd_ready;
    assign o_done   = sel ? hw.done_tick   : h.done_tick;
    assign o_busy   = sel ? hw.busy        : h.busy;
    assign o_status = sel ? hw.done_status : h.done_status;
    assign o_steps  = sel ? hw.steps       : h.steps;
    assign o_clr    = sel ? w_clr : s_clr;
    assign o_ld     = sel ? w_ld  : s_ld;
    assign o_en     = sel ? w_en  : s_en;
    assign o_up     = sel ? w_up  : s_up;
    assign o_d      = sel ? w_d   : s_d;
    assign o_q      = sel ? w_q   : s_q;

    int vectors = 0;
    int errors  = 0;

    int           mon_lat, mon_en, mon_up, mon_clr, mon_clr_at, mon_ld, mon_ready;
    int           mon_first, mon_last, mon_bad, mon_abort_act;
    logic [N-1:0] mon_q, mon_ld_d;

    task automatic issue(input logic [2:0] op, input logic [N-1:0] arg);
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: cmd_ready=%b required 1", o_ready);
        end
        d_valid = 1'b1;
        d_op    = op;
        d_arg   = arg;
        @(posedge clk);
        #1 d_valid = 1'b0;
    endtask

    // Follows the active command cycle by cycle from T+1 until done_tick.
    task automatic wait_done(input int abort_at);
        bit done = 1'b0;
        mon_lat = 0; mon_en = 0; mon_up = 0; mon_clr = 0; mon_clr_at = 0; mon_ld = 0;
        mon_ready = 0; mon_first = 0; mon_last = 0; mon_bad = 0; mon_abort_act = 0;
        mon_q = '0; mon_ld_d = '0;
        for (int k = 1; k <= 600 && !done; k++) begin
            d_abort = (k == abort_at);
            @(negedge clk);
            if (o_en) begin
                mon_en++;
                if (mon_first == 0) mon_first = k;
                mon_last = k;
                if (o_up) mon_up++;
            end
            if (k == abort_at) mon_abort_act = int'(o_en) + int'(o_clr) + int'(o_ld);
            if (o_clr) begin mon_clr++; mon_clr_at = k; end
            if (o_ld) begin mon_ld++; mon_ld_d = o_d; end
            if (o_ready) mon_ready++;
            if ((int'(o_clr) + int'(o_ld) + int'(o_en)) > 1 || (o_up && !o_en) || (!o_ld && o_d != '0))
                mon_bad++;
            if (o_done) begin
                done    = 1'b1;
                mon_lat = k;
                mon_q   = o_q;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        d_abort = 1'b0;
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done_tick=0 required 1 within 600 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", o_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({s_clr, s_ld, s_en, s_up, s_d} !== '0 || {w_clr, w_ld, w_en, w_up, w_d} !== '0) begin
            errors++; $display("FAIL rst_ctr: got %b%b%b%b %h want all 0", s_clr, s_ld, s_en, s_up, s_d);
        end
        vectors++;
        if ({h.done_tick, h.done_status, h.steps, h.busy, h.cmd_ready} !== '0) begin
            errors++; $display("FAIL rst_host: done=%b st=%b steps=%0d busy=%b rdy=%b want 0",
                               h.done_tick, h.done_status, h.steps, h.busy, h.cmd_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_load_step();
        issue(3'd1, 8'hF0);
        wait_done(0);
        vectors++; if (mon_lat !== 2) begin errors++; $display("FAIL t1_load_lat: got %0d want 2", mon_lat); end
        vectors++; if (mon_ld !== 1 || mon_ld_d !== 8'hF0) begin errors++; $display("FAIL t1_load_d: cycles %0d d=%h want 1 f0", mon_ld, mon_ld_d); end
        vectors++; if (mon_q !== 8'hF0) begin errors++; $display("FAIL t1_load_q: got %h want f0", mon_q); end
        issue(3'd2, 8'd5);
        wait_done(0);
        vectors++; if (mon_en !== 5 || mon_up !== 5) begin errors++; $display("FAIL t1_en: en=%0d up=%0d want 5 5", mon_en, mon_up); end
        vectors++; if (mon_first !== 1 || mon_last !== 5) begin errors++; $display("FAIL t1_consec: first=%0d last=%0d want 1 5", mon_first, mon_last); end
        vectors++; if (mon_q !== 8'hF5) begin errors++; $display("FAIL t1_q: got %h want f5", mon_q); end
        vectors++; if (o_status !== 2'b00 || o_steps !== 8'd5) begin errors++; $display("FAIL t1_status: st=%b steps=%0d want 00 5", o_status, o_steps); end
        vectors++; if (mon_lat !== 6) begin errors++; $display("FAIL t1_lat: got %0d want 6", mon_lat); end
        vectors++; if (mon_bad !== 0) begin errors++; $display("FAIL t1_exclusive: %0d bad cycles want 0", mon_bad); end
    endtask

    task automatic test_saturate();
        issue(3'd1, 8'hFD);
        wait_done(0);
        issue(3'd2, 8'd5);
        wait_done(0);
        vectors++; if (mon_en !== 2) begin errors++; $display("FAIL t2_sat_en: got %0d want 2", mon_en); end
        vectors++; if (mon_q !== 8'hFF) begin errors++; $display("FAIL t2_sat_q: got %h want ff", mon_q); end
        vectors++; if (o_status !== 2'b01 || o_steps !== 8'd2) begin errors++; $display("FAIL t2_sat_status: st=%b steps=%0d want 01 2", o_status, o_steps); end
        vectors++; if (mon_lat !== 4) begin errors++; $display("FAIL t2_sat_lat: got %0d want 4", mon_lat); end
        // Down-direction limit from 1.
        issue(3'd1, 8'h01);
        wait_done(0);
        issue(3'd3, 8'd4);
        wait_done(0);
        vectors++; if (mon_en !== 1 || mon_up !== 0 || mon_q !== 8'h00) begin errors++; $display("FAIL t2_satdn: en=%0d up=%0d q=%h want 1 0 00", mon_en, mon_up, mon_q); end
        vectors++; if (o_status !== 2'b01 || o_steps !== 8'd1) begin errors++; $display("FAIL t2_satdn_status: st=%b steps=%0d want 01 1", o_status, o_steps); end
        issue(3'd2, 8'd0);
        wait_done(0);
        vectors++; if (mon_en !== 0 || mon_lat !== 2 || o_status !== 2'b00 || o_steps !== 8'd0) begin
            errors++; $display("FAIL t2_zero: en=%0d lat=%0d st=%b steps=%0d want 0 2 00 0", mon_en, mon_lat, o_status, o_steps);
        end
        sel = 1'b1;
        issue(3'd1, 8'hFD);
        wait_done(0);
        issue(3'd2, 8'd5);
        wait_done(0);
        vectors++; if (mon_en !== 5 || mon_q !== 8'h02) begin errors++; $display("FAIL t2_wrap: en=%0d q=%h want 5 02", mon_en, mon_q); end
        vectors++; if (o_status !== 2'b00 || o_steps !== 8'd5) begin errors++; $display("FAIL t2_wrap_status: st=%b steps=%0d want 00 5", o_status, o_steps); end
        sel = 1'b0;
    endtask

    task automatic test_run();
        issue(3'd1, 8'd3);
        wait_done(0);
        issue(3'd5, 8'hAA);
        wait_done(0);
        vectors++; if (mon_en !== 3 || mon_up !== 0) begin errors++; $display("FAIL t3_en: en=%0d up=%0d want 3 0", mon_en, mon_up); end
        vectors++; if (mon_q !== 8'h00 || o_status !== 2'b00 || o_steps !== 8'd3) begin
            errors++; $display("FAIL t3_result: q=%h st=%b steps=%0d want 00 00 3", mon_q, o_status, o_steps);
        end
        vectors++; if (mon_lat !== 5) begin errors++; $display("FAIL t3_lat: got %0d want 5", mon_lat); end
        issue(3'd5, 8'd0);
        wait_done(0);
        vectors++; if (o_steps !== 8'd0 || mon_lat !== 2 || mon_en !== 0) begin
            errors++; $display("FAIL t3_at_target: steps=%0d lat=%0d en=%0d want 0 2 0", o_steps, mon_lat, mon_en);
        end
        issue(3'd1, 8'hFE);
        wait_done(0);
        issue(3'd4, 8'h55);
        wait_done(0);
        vectors++; if (mon_en !== 1 || mon_up !== 1 || mon_q !== 8'hFF || o_steps !== 8'd1) begin
            errors++; $display("FAIL t3_run_max: en=%0d up=%0d q=%h steps=%0d want 1 1 ff 1", mon_en, mon_up, mon_q, o_steps);
        end
        vectors++; if (mon_bad !== 0) begin errors++; $display("FAIL t3_exclusive: %0d bad cycles want 0", mon_bad); end
    endtask

    task automatic test_clear();
        issue(3'd0, 8'h77);
        wait_done(0);
        vectors++; if (mon_clr !== 1 || mon_clr_at !== 1) begin errors++; $display("FAIL t4_clr: cycles=%0d at=%0d want 1 1", mon_clr, mon_clr_at); end
        vectors++; if (mon_lat !== 2 || mon_q !== 8'h00) begin errors++; $display("FAIL t4_done: lat=%0d q=%h want 2 00", mon_lat, mon_q); end
        vectors++; if (mon_ready !== 0) begin errors++; $display("FAIL t4_ready: high %0d cycles want 0", mon_ready); end
        vectors++; if (mon_en !== 0 || mon_ld !== 0) begin errors++; $display("FAIL t4_other: en=%0d ld=%0d want 0 0", mon_en, mon_ld); end
    endtask

    task automatic test_abort();
        issue(3'd2, 8'd100);
        wait_done(4);
        vectors++; if (o_steps !== 8'd3 || o_status !== 2'b10) begin errors++; $display("FAIL t5_abort: steps=%0d st=%b want 3 10", o_steps, o_status); end
        vectors++; if (mon_abort_act !== 0) begin errors++; $display("FAIL t5_abort_quiet: %0d strobes want 0", mon_abort_act); end
        vectors++; if (mon_lat !== 5 || mon_q !== 8'h03) begin errors++; $display("FAIL t5_abort_lat: lat=%0d q=%h want 5 03", mon_lat, mon_q); end
        issue(3'd0, 8'd0);
        wait_done(1);
        vectors++; if (mon_clr !== 0 || mon_q !== 8'h03 || o_status !== 2'b10) begin
            errors++; $display("FAIL t5_abort_clr: clr=%0d q=%h st=%b want 0 03 10", mon_clr, mon_q, o_status);
        end
        // Abort while idle must be ignored.
        @(negedge clk);
        d_abort = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL t5_idle_abort: busy=%b done=%b rdy=%b want 0 0 1", o_busy, o_done, o_ready);
        end
        vectors++; if (o_status !== 2'b10 || o_steps !== 8'd0) begin errors++; $display("FAIL t5_hold: st=%b steps=%0d want 10 0", o_status, o_steps); end
        d_abort = 1'b0;
    endtask

    task automatic test_illegal();
        issue(3'd6, 8'hFF);
        wait_done(0);
        vectors++; if (mon_lat !== 1 || o_status !== 2'b11 || o_steps !== 8'd0) begin
            errors++; $display("FAIL t6_illegal: lat=%0d st=%b steps=%0d want 1 11 0", mon_lat, o_status, o_steps);
        end
        vectors++; if (mon_en + mon_clr + mon_ld !== 0) begin errors++; $display("FAIL t6_quiet: %0d strobes want 0", mon_en + mon_clr + mon_ld); end
        issue(3'd7, 8'h01);
        wait_done(0);
        vectors++; if (mon_lat !== 1 || o_status !== 2'b11) begin errors++; $display("FAIL t6_op7: lat=%0d st=%b want 1 11", mon_lat, o_status); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        issue(3'd2, 8'd50);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({s_clr, s_ld, s_en, s_up, s_d} !== '0) begin errors++; $display("FAIL t6_rst_ctr: got %b%b%b%b %h want 0", s_clr, s_ld, s_en, s_up, s_d); end
        vectors++;
        if ({h.done_tick, h.done_status, h.steps, h.busy, h.cmd_ready} !== '0) begin
            errors++; $display("FAIL t6_rst_host: done=%b st=%b steps=%0d busy=%b rdy=%b want 0",
                               h.done_tick, h.done_status, h.steps, h.busy, h.cmd_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++; if (o_ready !== 1'b1) begin errors++; $display("FAIL t6_rst_ready: got %b want 1", o_ready); end
        for (int k = 0; k < 6; k++) begin
            if (o_done) dones++;
            @(negedge clk);
        end
        vectors++; if (dones !== 0 || o_busy !== 1'b0) begin errors++; $display("FAIL t6_rst_nodone: dones=%0d busy=%b want 0 0", dones, o_busy); end
    endtask

    initial begin
        sel = 1'b0; d_valid = 1'b0; d_abort = 1'b0; d_op = 3'd0; d_arg = '0; reset = 1'b1;
        test_reset();
        test_load_step();
        test_saturate();
        test_run();
        test_clear();
        test_abort();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
